uart_recv: RTL and testbench

- 8N1 UART receiver: start bit, 8 data bits LSB first, 1 stop bit, no parity. Counterpart to the team's uart_send transmitter.
- Takes the asynchronous uart_rxd pin and synchronises it to sys_clk.
- Validates the start bit, samples every bit at mid-bit, and checks the stop bit.
- Presents each received byte with a one-cycle done strobe, or flags a framing error instead.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_recv.sv | 120 ++++++++++++
 tb/tb_uart_recv.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_send and uart_recv: default line rate, bit timing, FSM encoding.
// Latency: n/a (package); backpressure: n/a.
package uart_pkg;

    localparam int CLK_FREQ_DEF = 25_600_000;
    localparam int UART_BPS_DEF = 115200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // System clock cycles per bit, truncated.
    function automatic int bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the async rxd pin into sys_clk and flags a falling edge (candidate start bit).
// Latency: rx_s lags the pin by 2 cycles, start_edge by 2; backpressure: none.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic uart_rxd,
    output logic rx_s,
    output logic start_edge
);

    logic rx_d0_q;
    logic rx_d1_q;
    logic rx_d2_q;

    // Reset to the idle level so reset release cannot look like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_d0_q <= 1'b1;
            rx_d1_q <= 1'b1;
            rx_d2_q <= 1'b1;
        end else begin
            rx_d0_q <= uart_rxd;
            rx_d1_q <= rx_d0_q;
            rx_d2_q <= rx_d1_q;
        end
    end

    assign rx_s       = rx_d1_q;
    assign start_edge = rx_d2_q & ~rx_d1_q;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle done or frame-error strobe per frame.
// Latency: start edge to strobe ~3 + HALF_CNT + 9*BPS_CNT cycles; backpressure: none, bytes must be taken on uart_done.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int UART_BPS = UART_BPS_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       uart_frame_err,
    output logic       uart_rx_busy
);

    localparam int BPS_CNT  = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BPS_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

    logic rx_s;
    logic start_edge;

    uart_rx_sync u_sync (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_rxd   (uart_rxd),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    uart_state_e state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = 16'd0;
                if (start_edge) state_d = START;
            end
            START: begin
                // A start bit that is high again at its centre was a glitch.
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = 16'd0;
                    bit_cnt_d = 3'd0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d          = 16'd0;
                    shift_d[bit_cnt_q] = rx_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at the stop-bit centre re-arms in time for a zero-gap next frame.
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 16'd0;
                    state_d   = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                clk_cnt_d = 16'd0;
                state_d   = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            data_q    <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign uart_data      = data_q;
    assign uart_done      = done_q;
    assign uart_frame_err = err_q;
    assign uart_rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at 25.6 MHz / 115200 baud (222 cycles per bit).
module tb_uart_recv;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       uart_frame_err;
    logic       uart_rx_busy;

    uart_recv dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .uart_rxd       (uart_rxd),
        .uart_data      (uart_data),
        .uart_done      (uart_done),
        .uart_frame_err (uart_frame_err),
        .uart_rx_busy   (uart_rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    localparam int BIT  = 222;
    localparam int LAT  = 3 + 111 + 9 * 222;   // 2112

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         viol = 0;
    int         last_done_t = 0;
    int         prev_done_t = 0;
    logic [7:0] last_rx = 8'h00;
    logic       prev_strobe = 1'b0;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                if (uart_done && uart_frame_err) viol++;
                if ((uart_done || uart_frame_err) && prev_strobe) viol++;
                if (uart_done) begin
                    done_cnt++;
                    prev_done_t = last_done_t;
                    last_done_t = cyc;
                    last_rx = uart_data;
                end
                if (uart_frame_err) err_cnt++;
            end
            prev_strobe = uart_done | uart_frame_err;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Caller must be 1 ns after a posedge; returns in the same phase.
    int t_edge;
    int busy_lo;
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int blen);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        t_edge = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (blen / 2) @(posedge sys_clk);
            #1;
            if (!uart_rx_busy) busy_lo++;
            repeat (blen - blen / 2) @(posedge sys_clk);
            #1;
        end
        uart_rxd = 1'b1;
    endtask

    int d0, e0, lat, gap;

    initial begin
        idle(5);
        check("rst_data", uart_data, 8'h00);
        check("rst_done", uart_done, 1'b0);
        check("rst_err",  uart_frame_err, 1'b0);
        check("rst_busy", uart_rx_busy, 1'b0);
        sys_rst_n = 1'b1;
        idle(20);
        check("no_false_edge", done_cnt + err_cnt, 0);

        // Single byte
        busy_lo = 0;
        send_frame(8'h55, 1'b1, BIT);
        lat = last_done_t - t_edge;
        idle(20);
        check("single_done_cnt", done_cnt, 1);
        check("single_data", uart_data, 8'h55);
        check("single_busy_held", busy_lo, 0);
        check("single_no_err", err_cnt, 0);
        check("single_latency", (lat >= LAT - 2 && lat <= LAT + 2) ? LAT : lat, LAT);
        check("idle_busy", uart_rx_busy, 1'b0);

        // Back-to-back, zero gap
        idle(100);
        send_frame(8'hA3, 1'b1, BIT);
        check("b2b_first", last_rx, 8'hA3);
        send_frame(8'h0F, 1'b1, BIT);
        idle(20);
        gap = last_done_t - prev_done_t;
        check("b2b_done_cnt", done_cnt, 3);
        check("b2b_second", last_rx, 8'h0F);
        check("b2b_gap", gap, 2220);

        // Glitch: low for 50 cycles
        idle(100);
        d0 = done_cnt; e0 = err_cnt;
        uart_rxd = 1'b0;
        idle(50);
        uart_rxd = 1'b1;
        idle(10);
        check("glitch_busy_hi", uart_rx_busy, 1'b1);
        idle(60);
        check("glitch_busy_dropped", uart_rx_busy, 1'b0);
        idle(300);
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_no_err", err_cnt - e0, 0);

        // Framing error
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, BIT);
        idle(300);
        check("ferr_err_cnt", err_cnt - e0, 1);
        check("ferr_no_done", done_cnt - d0, 0);
        check("ferr_data_held", uart_data, 8'h0F);

        // Break: line held low for 20 bit times
        d0 = done_cnt; e0 = err_cnt;
        uart_rxd = 1'b0;
        idle(20 * BIT);
        check("break_one_err", err_cnt - e0, 1);
        check("break_busy_idle", uart_rx_busy, 1'b0);
        uart_rxd = 1'b1;
        idle(500);
        check("break_err_total", err_cnt - e0, 1);
        check("break_no_done", done_cnt - d0, 0);
        check("mono_viol", viol, 0);

        // Reset during data bit 4 of 0xFF
        uart_rxd = 1'b0;
        idle(BIT);
        uart_rxd = 1'b1;
        idle(4 * BIT + BIT / 2);
        check("pre_rst_busy", uart_rx_busy, 1'b1);
        sys_rst_n = 1'b0;
        idle(5);
        check("midrst_data", uart_data, 8'h00);
        check("midrst_done", uart_done, 1'b0);
        check("midrst_err",  uart_frame_err, 1'b0);
        check("midrst_busy", uart_rx_busy, 1'b0);
        sys_rst_n = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        idle(3000);
        check("postrst_quiet", (done_cnt - d0) + (err_cnt - e0), 0);
        send_frame(8'h81, 1'b1, BIT);
        idle(20);
        check("postrst_done", done_cnt - d0, 1);
        check("postrst_data", uart_data, 8'h81);

        // Baud tolerance, -3% and +3%
        idle(100);
        send_frame(8'hC6, 1'b1, 215);
        idle(100);
        check("fast_data", last_rx, 8'hC6);
        check("fast_done", done_cnt - d0, 2);
        uart_data_clear();
        send_frame(8'hC6, 1'b1, 229);
        idle(100);
        check("slow_data", last_rx, 8'hC6);
        check("slow_done", done_cnt - d0, 3);
        check("final_err_none", err_cnt - e0, 0);
        check("final_viol", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Poison the monitor's copy so the slow-baud check cannot pass on the previous byte.
    task automatic uart_data_clear();
        last_rx = 8'h00;
    endtask

endmodule
